id_ex_hazard_ctrl: RTL

- Write-side controller for the ID/EX pipeline register.
- Detects load-use hazards between the instruction in ID and a load sitting in ID/EX.
- Stalls PC and IF/ID, and injects bubbles by zeroing the WB/M/EX control bundles that are written into ID/EX.
- Flushes IF/ID, ID/EX and EX/MEM when a branch resolves taken. Supports multi-cycle load latency through a countdown stall state machine.

---
 rtl/id_ex_hazard_ctrl_pkg.sv | 15 +
 rtl/id_ex_hazard_ctrl_hazard_compare.sv | 22 ++
 rtl/id_ex_hazard_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX write-side hazard controller.
package id_ex_hazard_ctrl_pkg;

   typedef enum logic {
      StRun   = 1'b0,
      StStall = 1'b1
   } state_e;

   localparam int unsigned WB_W        = 2;
   localparam int unsigned M_W         = 2;
   localparam int unsigned EX_W        = 4;
   localparam int unsigned MEMREAD_BIT = 1;
   localparam logic [4:0]  REG_ZERO    = 5'd0;

endpackage

// File: rtl/id_ex_hazard_ctrl_hazard_compare.sv
// Combinational load-use hazard detection between the ID instruction and a load in ID/EX.
module id_ex_hazard_ctrl_hazard_compare
   import id_ex_hazard_ctrl_pkg::*;
(
   input  logic       idex_mem_read_i,
   input  logic [4:0] idex_rt_i,
   input  logic [4:0] ifid_rs_i,
   input  logic [4:0] ifid_rt_i,
   input  logic       id_uses_rt_i,
   output logic       hz_o
);

   logic rs_match;
   logic rt_match;

   assign rs_match = (idex_rt_i == ifid_rs_i);
   assign rt_match = id_uses_rt_i & (idex_rt_i == ifid_rt_i);

   // A load into $0 produces nothing to wait for.
   assign hz_o = idex_mem_read_i & (idex_rt_i != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX write-side controller: load-use stalls, bubble injection and branch flushes.
// Optional perf counters (stall_count_o, flush_count_o) under HAZARD_PERF_CNT_EN.
module id_ex_hazard_ctrl
   import id_ex_hazard_ctrl_pkg::*;
#(
   parameter int unsigned STALL_CYCLES = 1,
   parameter int unsigned CNT_W        = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [4:0]      ifid_rs_i,
   input  logic [4:0]      ifid_rt_i,
   input  logic            id_uses_rt_i,
   input  logic            idex_mem_read_i,
   input  logic [4:0]      idex_rt_i,
   input  logic            branch_taken_i,
   input  logic [WB_W-1:0] wb_ctrl_i,
   input  logic [M_W-1:0]  m_ctrl_i,
   input  logic [EX_W-1:0] ex_ctrl_i,
   output logic [WB_W-1:0] wb_ctrl_o,
   output logic [M_W-1:0]  m_ctrl_o,
   output logic [EX_W-1:0] ex_ctrl_o,
   output logic            pc_write_o,
   output logic            ifid_write_o,
   output logic            ifid_flush_o,
   output logic            exmem_flush_o,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]     stall_count_o,
   output logic [31:0]     flush_count_o,
`endif
   output logic            stall_active_o
);

   localparam bit             MultiStall = (STALL_CYCLES > 1);
   localparam logic [CNT_W-1:0] CntInit  = MultiStall ? CNT_W'(STALL_CYCLES - 2) : '0;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             stall_active_q;
   logic             hz;
   logic             in_stall;

   id_ex_hazard_ctrl_hazard_compare u_hazard_compare (
      .idex_mem_read_i (idex_mem_read_i),
      .idex_rt_i       (idex_rt_i),
      .ifid_rs_i       (ifid_rs_i),
      .ifid_rt_i       (ifid_rt_i),
      .id_uses_rt_i    (id_uses_rt_i),
      .hz_o            (hz)
   );

   assign in_stall = (state_q == StStall);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= StRun;
         cnt_q          <= '0;
         stall_active_q <= 1'b0;
      end else if (branch_taken_i) begin
         state_q        <= StRun;
         cnt_q          <= '0;
         stall_active_q <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (hz && MultiStall) begin
                  state_q        <= StStall;
                  cnt_q          <= CntInit;
                  stall_active_q <= 1'b1;
               end
            end
            StStall: begin
               if (cnt_q == '0) begin
                  state_q        <= StRun;
                  stall_active_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q        <= StRun;
               cnt_q          <= '0;
               stall_active_q <= 1'b0;
            end
         endcase
      end
   end

   assign stall_active_o = stall_active_q;

   // Priority: reset, then branch flush, then stall/hazard bubble, then pass-through.
   always_comb begin
      wb_ctrl_o     = '0;
      m_ctrl_o      = '0;
      ex_ctrl_o     = '0;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      exmem_flush_o = 1'b0;
      if (rst_i) begin
         ifid_flush_o  = 1'b1;
         exmem_flush_o = 1'b1;
      end else if (branch_taken_i) begin
         pc_write_o    = 1'b1;
         ifid_write_o  = 1'b1;
         ifid_flush_o  = 1'b1;
         exmem_flush_o = 1'b1;
      end else if (!(in_stall || hz)) begin
         pc_write_o   = 1'b1;
         ifid_write_o = 1'b1;
         wb_ctrl_o    = wb_ctrl_i;
         m_ctrl_o     = m_ctrl_i;
         ex_ctrl_o    = ex_ctrl_i;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_count_q;
   logic [31:0] flush_count_q;
   logic        stall_inc;

   assign stall_inc = ~branch_taken_i & (in_stall | hz);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         if (stall_inc && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
         if (branch_taken_i && (flush_count_q != '1)) begin
            flush_count_q <= flush_count_q + 32'd1;
         end
      end
   end

   assign stall_count_o = stall_count_q;
   assign flush_count_o = flush_count_q;
`endif

endmodule
